// File: rtl/lsu_data_mem.sv
// lsu_data_mem: byte-addressable data memory with a RISC-V load/store front end (MEM stage).
// Latency: every accepted request answers exactly RD_LATENCY (1 or 2) cycles after the accept edge.
// Backpressure: req_ready is low only while the post-reset clear runs; responses cannot be stalled.
//
// Ports:
//   clk, reset (async active-low)
//   req_valid/req_ready handshake; req_we, req_funct3, req_addr, req_wdata describe the access
//   resp_valid one-cycle pulse per request; resp_rdata extended load data; resp_err fault flag
//   init_done high once the array has been zeroed and requests are accepted
module lsu_data_mem #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int            AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        r_state;
  logic [AW-1:0] r_clr_idx;
  logic          r_ready;
  logic [31:0]   r_mem [DEPTH_WORDS];

  // Clear FSM: one word zeroed per cycle; ready is registered so it rises on
  // the same edge that writes the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == LAST_IDX) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign init_done = r_ready;

  // Request decode
  logic          w_acc;
  logic [AW-1:0] w_widx;
  logic [1:0]    w_off;
  logic          w_oob;
  logic          w_bad_f3;
  logic          w_st_uns;
  logic          w_mis_h;
  logic          w_mis_w;
  logic          w_err;
  logic          w_wr;

  assign w_acc    = req_valid & r_ready;
  assign w_widx   = req_addr[AW+1:2];
  assign w_off    = req_addr[1:0];
  // DEPTH_WORDS is a power of two, so any set bit above the index is out of range.
  assign w_oob    = |req_addr[31:AW+2];
  assign w_bad_f3 = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
  assign w_st_uns = req_we & req_funct3[2];
  assign w_mis_h  = (req_funct3[1:0] == 2'b01) & req_addr[0];
  assign w_mis_w  = (req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00);
  assign w_err    = w_oob | w_bad_f3 | w_st_uns | w_mis_h | w_mis_w;
  assign w_wr     = w_acc & req_we & ~w_err;

  // Store lanes: data is replicated across lanes so the byte enables alone pick the target.
  logic [3:0]  w_be;
  logic [31:0] w_wdat;

  always_comb begin
    w_be   = 4'b1111;
    w_wdat = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << w_off;
        w_wdat = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = 4'b0011 << w_off;
        w_wdat = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wdat = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  // Load path: read and extend at accept, so the pipeline only carries final data.
  logic [31:0] w_rword;
  logic [31:0] w_shift;
  logic [31:0] w_ldata;
  logic [31:0] w_rdata0;

  assign w_rword = r_mem[w_widx];
  assign w_shift = w_rword >> {w_off, 3'b000};

  always_comb begin
    w_ldata = w_rword;
    case (req_funct3)
      3'b000:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_ldata = {24'd0, w_shift[7:0]};
      3'b001:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_ldata = {16'd0, w_shift[15:0]};
      default: w_ldata = w_rword;
    endcase
  end

  assign w_rdata0 = (w_acc & ~req_we & ~w_err) ? w_ldata : 32'd0;

  // Response pipeline, RD_LATENCY stages deep; reset flushes anything in flight.
  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY-1:0] r_err;
  logic [31:0]           r_dat [RD_LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      r_err <= '0;
      for (int s = 0; s < RD_LATENCY; s++) r_dat[s] <= '0;
    end else begin
      r_vld[0] <= w_acc;
      r_err[0] <= w_acc & w_err;
      r_dat[0] <= w_rdata0;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_err[s] <= r_err[s-1];
        r_dat[s] <= r_dat[s-1];
      end
    end
  end

  assign resp_valid = r_vld[RD_LATENCY-1];
  assign resp_err   = r_err[RD_LATENCY-1];
  assign resp_rdata = r_dat[RD_LATENCY-1];

endmodule
